load_store_unit: RTL and testbench

- Sits between the core's memory stage and DataMem; turns RV32I load/store requests into word accesses on DataMem's Address/Wdata/MemRW/Rdata port.
- Byte and halfword stores use a read-modify-write sequence; loads return sign- or zero-extended data.
- Decodes the GPIO address: the GPIO output register is written instead of memory.
- Flags misaligned, out-of-range and illegal-funct3 accesses.

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the DataMem word port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store to DataMem word port: RMW for sub-word stores, load extension, GPIO decode, error flags.
// Latency GPIO/error 1, SW/loads 2, SB/SH 3 cycles; accepts only in IDLE, no response back-pressure.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] GPIO_ADDR = 32'h0000ABCD,
  parameter int unsigned GPIO_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  load_store_unit_if.slave  bus,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;

  logic        accept;
  logic        gpio_hit;
  logic        req_bad;
  logic [31:0] gpio_ext;
  logic [31:0] merged;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ofs[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] ofs,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    if (f3[1:0] == 2'b00) begin
      case (ofs)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (f3[1:0] == 2'b01) begin
      if (ofs[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = gpio_q;
  end

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign gpio_hit = (bus.req_addr == GPIO_ADDR);

  // Stores only exist in B/H/W widths; the unsigned encodings are load-only.
  always_comb begin
    logic illegal, misal;
    illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
              (bus.req_we && bus.req_funct3[2]);
    misal   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_bad = illegal || misal || (bus.req_addr >= MEM_BYTES);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gpio_d  = gpio_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = 1'b0;
          rdata_d = '0;
          if (gpio_hit) begin
            if (bus.req_we) gpio_d  = bus.req_wdata[GPIO_W-1:0];
            else            rdata_d = gpio_ext;
            state_d = RESP;
          end else if (req_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        word_d = bus.mem_rdata;
        if (we_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_ext(f3_q, addr_q[1:0], bus.mem_rdata);
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gpio_q  <= gpio_d;
    end
  end

  // Outputs decode straight from state so reset kills mem_rw without waiting for an edge.
  assign merged         = store_merge(f3_q, addr_q[1:0], word_q, wdata_q);
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign bus.mem_rw     = (state_q == WR);
  assign bus.mem_addr   = ((state_q == RD) || (state_q == WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata  = (state_q == WR) ? merged : 32'd0;
  assign gpio_out       = gpio_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with scoreboard plus reset and back-to-back sequences.
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] mem [64];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(64), .GPIO_ADDR(32'h0000ABCD), .GPIO_W(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .gpio_out (gpio_out)
  );

  always #5 clock = ~clock;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clock) begin
    if (bus.mem_rw) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre_en;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_word9;
    logic [31:0] exp_wdata;
    logic [31:0] exp_gpio;
  } vec_t;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (bus.mem_rw) begin
      wr_cnt++;
      last_wdata = bus.mem_wdata;
      last_waddr = bus.mem_addr;
    end
    if (bus.resp_valid) begin
      exp_t e;
      resp_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none");
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clock);
    if (v.pre_en) mem[9] = v.pre;
    wr_cnt = 0;
    check($sformatf("ready_before_%0d", idx), {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.resp_valid && lat < 10);
    check($sformatf("latency_%0d", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("wr_cycles_%0d", idx), 32'(wr_cnt), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      check($sformatf("mem_wdata_%0d", idx), last_wdata, v.exp_wdata);
      check($sformatf("mem_addr_%0d", idx), last_waddr, {v.addr[31:2], 2'b00});
    end
    @(negedge clock);
    check($sformatf("word9_%0d", idx), mem[9], v.exp_word9);
    check($sformatf("gpio_%0d", idx), gpio_out, v.exp_gpio);
  endtask

  initial begin
    vec_t vecs [$];
    int   lat;

    for (int i = 0; i < 64; i++) mem[i] = 32'h01010101 * i;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    //        we  f3      addr          wdata         pre  preload       rdata         err lat wr word9         wdata         gpio
    vecs.push_back('{1, 3'b000, 32'd37,       32'hFFFFFFAA, 1, 32'h11223344, 32'h0,        0, 3, 1, 32'h1122AA44, 32'h1122AA44, 32'h0});
    vecs.push_back('{0, 3'b000, 32'd39,       32'h0,        1, 32'h80FF7F01, 32'hFFFFFF80, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{0, 3'b100, 32'd39,       32'h0,        0, 32'h0,        32'h00000080, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{0, 3'b001, 32'd38,       32'h0,        0, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{0, 3'b010, 32'd36,       32'h0,        0, 32'h0,        32'h80FF7F01, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{0, 3'b101, 32'd38,       32'h0,        0, 32'h0,        32'h000080FF, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{0, 3'b000, 32'd37,       32'h0,        0, 32'h0,        32'h0000007F, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h0});
    vecs.push_back('{1, 3'b001, 32'd38,       32'h1234BEEF, 0, 32'h0,        32'h0,        0, 3, 1, 32'hBEEF7F01, 32'hBEEF7F01, 32'h0});
    vecs.push_back('{1, 3'b010, 32'd36,       32'hDEADBEEF, 1, 32'h80FF7F01, 32'h0,        0, 2, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1, 3'b010, 32'h0000ABCD, 32'h0000005A, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h5A});
    vecs.push_back('{0, 3'b010, 32'h0000ABCD, 32'h0,        0, 32'h0,        32'h0000005A, 0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h5A});
    vecs.push_back('{0, 3'b001, 32'd37,       32'h0,        1, 32'h80FF7F01, 32'h0,        1, 1, 0, 32'h80FF7F01, 32'h0,        32'h5A});
    vecs.push_back('{1, 3'b010, 32'd38,       32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 1, 0, 32'h80FF7F01, 32'h0,        32'h5A});
    vecs.push_back('{1, 3'b010, 32'd256,      32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 1, 0, 32'h80FF7F01, 32'h0,        32'h5A});
    vecs.push_back('{1, 3'b100, 32'd36,       32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 1, 0, 32'h80FF7F01, 32'h0,        32'h5A});
    vecs.push_back('{0, 3'b011, 32'd36,       32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 32'h80FF7F01, 32'h0,        32'h5A});
    vecs.push_back('{1, 3'b000, 32'h0000ABCD, 32'h89ABCDEF, 0, 32'h0,        32'h0,        0, 1, 0, 32'h80FF7F01, 32'h0,        32'h89ABCDEF});
    vecs.push_back('{0, 3'b001, 32'h0000ABCD, 32'h0,        0, 32'h0,        32'h89ABCDEF, 0, 1, 0, 32'h80FF7F01, 32'h0,        32'h89ABCDEF});
    vecs.push_back('{0, 3'b000, 32'd255,      32'h0,        0, 32'h0,        32'h0000003F, 0, 2, 0, 32'h80FF7F01, 32'h0,        32'h89ABCDEF});
    vecs.push_back('{1, 3'b001, 32'd254,      32'h0000A5A5, 0, 32'h0,        32'h0,        0, 3, 1, 32'h80FF7F01, 32'hA5A53F3F, 32'h89ABCDEF});

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted while an SH sits in RD: no write, no response, clean state afterwards.
    @(negedge clock);
    mem[9] = 32'h11223344;
    wr_cnt = 0;
    resp_cnt = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'd36;
    bus.req_wdata  = 32'h0000FFFF;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    check("mid_rd_mem_addr", bus.mem_addr, 32'd36);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_rst_wr_cycles", 32'(wr_cnt), 32'd0);
    check("mid_rst_resp_cnt", 32'(resp_cnt), 32'd0);
    check("mid_rst_word9", mem[9], 32'h11223344);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_gpio", gpio_out, 32'd0);

    // req_valid held across two requests: the LW must wait until the SW has responded.
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'd12;
    bus.req_wdata  = 32'hCAFEF00D;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    exp_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    @(posedge clock);
    #1;
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!bus.resp_valid) check("b2b_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    end while (!bus.resp_valid && lat < 10);
    check("b2b_sw_latency", 32'(lat), 32'd2);
    check("b2b_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
    lat = 0;
    while (!bus.req_ready && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("b2b_idle_gap", 32'(lat), 32'd1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.resp_valid && lat < 10);
    check("b2b_lw_latency", 32'(lat), 32'd2);
    check("b2b_mem3", mem[3], 32'hCAFEF00D);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
